// File: rtl/mips_cpu_muldiv.sv
// Multi-cycle HI/LO unit: serial shift-add multiply, restoring divide, MTHI/MTLO.
// Optional MULDIV_FAST_MULT_EN: single-cycle 64-bit multiplier for MULT/MULTU.
module mips_cpu_muldiv #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ITERS = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [2:0]      op,
  input  logic            write,
  input  logic            mt_lo,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            done
);

  localparam int unsigned    CntW    = $clog2(ITERS);
  localparam logic [CntW-1:0] CntLast = CntW'(ITERS - 1);

  localparam logic [2:0] OpMult  = 3'b001;
  localparam logic [2:0] OpMultu = 3'b010;
  localparam logic [2:0] OpDiv   = 3'b011;
  localparam logic [2:0] OpDivu  = 3'b100;
  localparam logic [2:0] OpMtx   = 3'b101;

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e state_q, state_d;

  logic [XLEN-1:0]   ma_q, ma_d, mb_q, mb_d;
  logic [2*XLEN-1:0] p_q, p_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              is_div_q, is_div_d;
  logic              neg_q, neg_d;
  logic              sa_q, sa_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic              done_q, done_d;

  logic              is_mul_op, is_div_op, signed_op, issue;
  logic              in_sa, in_sb;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_step;
  logic [XLEN:0]     rem_sh;
  logic [XLEN+1:0]   div_diff;
  logic              borrow;
  logic [2*XLEN-1:0] div_step;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo, rem;
  logic              unused_bits;

  assign is_mul_op = (op == OpMult) || (op == OpMultu);
  assign is_div_op = (op == OpDiv) || (op == OpDivu);
  assign signed_op = (op == OpMult) || (op == OpDiv);
  assign issue     = (state_q == StIdle) && write && (is_mul_op || is_div_op);

  assign in_sa = signed_op & a[XLEN-1];
  assign in_sb = signed_op & b[XLEN-1];
  assign mag_a = in_sa ? -a : a;
  assign mag_b = in_sb ? -b : b;

  // Multiply: upper half accumulates, lower half shifts the multiplier out.
  assign mul_sum  = {1'b0, p_q[2*XLEN-1:XLEN]} + {1'b0, (p_q[0] ? ma_q : '0)};
  assign mul_step = {mul_sum, p_q[XLEN-1:1]};

  // Divide: upper half is the partial remainder, lower half collects quotient bits.
  assign rem_sh   = p_q[2*XLEN-1:XLEN-1];
  assign div_diff = {1'b0, rem_sh} - {2'b00, mb_q};
  assign borrow   = div_diff[XLEN+1];
  assign div_step = {(borrow ? rem_sh[XLEN-1:0] : div_diff[XLEN-1:0]), p_q[XLEN-2:0], ~borrow};

  assign unused_bits = ^{rem_sh[XLEN], div_diff[XLEN]};

`ifdef MULDIV_FAST_MULT_EN
  assign prod = {{XLEN{1'b0}}, ma_q} * {{XLEN{1'b0}}, mb_q};
`else
  assign prod = p_q;
`endif
  assign prod_fix = neg_q ? -prod : prod;
  assign quo      = p_q[XLEN-1:0];
  assign rem      = p_q[2*XLEN-1:XLEN];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (issue) begin
`ifdef MULDIV_FAST_MULT_EN
          state_d = is_mul_op ? StFix : StRun;
`else
          state_d = StRun;
`endif
        end
      end
      StRun:   if (cnt_q == CntLast) state_d = StFix;
      StFix:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q != StIdle);
    hi   = hi_q;
    lo   = lo_q;
    done = done_q;
  end

  always_comb begin
    ma_d     = ma_q;
    mb_d     = mb_q;
    p_d      = p_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    sa_d     = sa_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (issue) begin
          ma_d     = mag_a;
          mb_d     = mag_b;
          p_d      = {{XLEN{1'b0}}, (is_div_op ? mag_a : mag_b)};
          cnt_d    = '0;
          is_div_d = is_div_op;
          neg_d    = in_sa ^ in_sb;
          sa_d     = in_sa;
        end else if (write && (op == OpMtx)) begin
          if (mt_lo) lo_d = a;
          else       hi_d = a;
        end
      end
      StRun: begin
        cnt_d = cnt_q + 1'b1;
        p_d   = is_div_q ? div_step : mul_step;
      end
      StFix: begin
        done_d = 1'b1;
        if (is_div_q) begin
          lo_d = neg_q ? -quo : quo;
          hi_d = sa_q ? -rem : rem;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ma_q     <= '0;
      mb_q     <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      sa_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      p_q      <= p_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      sa_q     <= sa_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

endmodule
